inst_encoder: RTL and testbench

INST_ENCODER -- requirements
Module: inst_encoder

---
 rtl/renas_package.sv | 32 +++
 rtl/renas_user_parameters.sv | 8 +
 rtl/inst_fifo.sv | 56 +++++
 rtl/inst_encoder.sv | 178 +++++++++++++++++
 tb/tb_inst_encoder.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/renas_package.sv
// renas_package
// Purpose: request operation type and RV32I opcode constants for inst_encoder.
// Contents: enc_op_e (4-bit request operation), OPC_* major opcodes, NOP word.
package renas_package;

  typedef enum logic [3:0] {
    OP_LUI    = 4'd0,
    OP_AUIPC  = 4'd1,
    OP_JAL    = 4'd2,
    OP_JALR   = 4'd3,
    OP_BRANCH = 4'd4,
    OP_LOAD   = 4'd5,
    OP_STORE  = 4'd6,
    OP_OPIMM  = 4'd7,
    OP_OP     = 4'd8,
    OP_LI     = 4'd9,
    OP_NOP    = 4'd10
  } enc_op_e;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;

  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

endpackage : renas_package

// File: rtl/renas_user_parameters.sv
// renas_user_parameters
// Purpose: user-tunable global constants shared by the RENAS encoder blocks.
// Contents: INST_LENGTH, the width of one encoded instruction word.
package renas_user_parameters;

  localparam int INST_LENGTH = 32;

endpackage : renas_user_parameters

// File: rtl/inst_fifo.sv
// inst_fifo
// Purpose: first-word-fall-through buffer for encoded instruction words.
// Ports:
//   clk, rst           clock, synchronous active-high reset (empties buffer)
//   push, wr_data      write one word (ignored while full)
//   pop                remove head (ignored while empty)
//   rd_valid, rd_data  head valid / head word (zero when empty)
//   full               buffer holds FIFO_DEPTH words
module inst_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              full
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              do_push, do_pop;

  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign rd_valid = (count_q != '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && rd_valid;
  // Empty buffer shows zero so the output is clean out of reset.
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule : inst_fifo

// File: rtl/inst_encoder.sv
// inst_encoder
// Purpose: turns operation requests into RV32I instruction words and queues
//   them. LI with a large immediate expands into LUI followed by ADDI.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid / req_ready         request handshake
//   req_op, req_funct3, req_alt   operation, funct3, bit-30 select (SUB/SRA/SRAI)
//   req_rd, req_rs1, req_rs2      register indices
//   req_imm                       full immediate value (not pre-shifted)
//   inst_valid / inst_ready       output word handshake
//   inst_data                     encoded word at the buffer head
//   enc_err                       one-cycle pulse for a rejected request
// Build option: RENAS_ENC_CHECK_EN enables legality checks; rejected requests
//   are accepted but dropped and enc_err pulses. Without it immediates are
//   truncated to their fields and enc_err stays 0.
module inst_encoder
  import renas_package::*;
  import renas_user_parameters::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  enc_op_e                req_op,
  input  logic [2:0]             req_funct3,
  input  logic                   req_alt,
  input  logic [4:0]             req_rd,
  input  logic [4:0]             req_rs1,
  input  logic [4:0]             req_rs2,
  input  logic [31:0]            req_imm,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [INST_LENGTH-1:0] inst_data,
  output logic                   enc_err
);

  typedef enum logic {ST_IDLE, ST_EXPAND} state_e;

  state_e                 state_q, state_d;
  logic [4:0]             li_rd_q, li_rd_d;
  logic [11:0]            li_lo_q, li_lo_d;
  logic                   enc_err_q, enc_err_d;

  logic [INST_LENGTH-1:0] enc_word, push_data;
  logic                   enc_bad, push, fifo_full, accept;
  logic                   li_small, is_shift;
  logic [19:0]            li_upper;

  assign req_ready = !rst && (state_q == ST_IDLE) && !fifo_full;
  assign accept    = req_valid && req_ready;
  assign enc_err   = enc_err_q;

  // Immediate fits a sign-extended 12-bit field.
  assign li_small  = (&req_imm[31:11]) || !(|req_imm[31:11]);
  // ADDI sign-extends its 12 bits, so bump the upper part when bit 11 is set.
  assign li_upper  = req_imm[31:12] + {19'd0, req_imm[11]};
  assign is_shift  = (req_funct3 == 3'd1) || (req_funct3 == 3'd5);

  // Word encoder
  always_comb begin
    enc_word = '0;
    case (req_op)
      OP_LUI:    enc_word = {req_imm[31:12], req_rd, OPC_LUI};
      OP_AUIPC:  enc_word = {req_imm[31:12], req_rd, OPC_AUIPC};
      OP_JAL:    enc_word = {req_imm[20], req_imm[10:1], req_imm[11],
                             req_imm[19:12], req_rd, OPC_JAL};
      OP_JALR:   enc_word = {req_imm[11:0], req_rs1, 3'b000, req_rd, OPC_JALR};
      OP_BRANCH: enc_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1,
                             req_funct3, req_imm[4:1], req_imm[11], OPC_BRANCH};
      OP_LOAD:   enc_word = {req_imm[11:0], req_rs1, req_funct3, req_rd, OPC_LOAD};
      OP_STORE:  enc_word = {req_imm[11:5], req_rs2, req_rs1, req_funct3,
                             req_imm[4:0], OPC_STORE};
      OP_OPIMM:  enc_word = is_shift
                   ? {1'b0, req_alt, 5'd0, req_imm[4:0], req_rs1, req_funct3, req_rd, OPC_OPIMM}
                   : {req_imm[11:0], req_rs1, req_funct3, req_rd, OPC_OPIMM};
      OP_OP:     enc_word = {1'b0, req_alt, 5'd0, req_rs2, req_rs1, req_funct3,
                             req_rd, OPC_OP};
      OP_LI:     enc_word = li_small
                   ? {req_imm[11:0], 5'd0, 3'b000, req_rd, OPC_OPIMM}
                   : {li_upper, req_rd, OPC_LUI};
      OP_NOP:    enc_word = NOP_WORD;
      default:   enc_word = NOP_WORD;
    endcase
  end

  // Legality checks
`ifdef RENAS_ENC_CHECK_EN
  logic i_ok, b_ok, j_ok, u_ok, shamt_ok;
  assign i_ok     = li_small;
  assign b_ok     = ((&req_imm[31:12]) || !(|req_imm[31:12])) && !req_imm[0];
  assign j_ok     = ((&req_imm[31:20]) || !(|req_imm[31:20])) && !req_imm[0];
  assign u_ok     = (req_imm[11:0] == 12'd0);
  assign shamt_ok = (req_imm[31:5] == 27'd0);

  always_comb begin
    enc_bad = 1'b0;
    case (req_op)
      OP_LUI, OP_AUIPC: enc_bad = !u_ok;
      OP_JAL:           enc_bad = !j_ok;
      OP_JALR:          enc_bad = !i_ok;
      OP_BRANCH:        enc_bad = !b_ok || (req_funct3 == 3'd2) || (req_funct3 == 3'd3);
      OP_LOAD:          enc_bad = !i_ok || (req_funct3 == 3'd3) || (req_funct3 == 3'd6)
                                  || (req_funct3 == 3'd7);
      OP_STORE:         enc_bad = !i_ok || (req_funct3 > 3'd2);
      OP_OPIMM:         enc_bad = is_shift ? !shamt_ok : !i_ok;
      default:          enc_bad = 1'b0;
    endcase
  end
`else
  assign enc_bad = 1'b0;
`endif

  // Control FSM
  always_comb begin
    state_d   = state_q;
    li_rd_d   = li_rd_q;
    li_lo_d   = li_lo_q;
    enc_err_d = 1'b0;
    push      = 1'b0;
    push_data = enc_word;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (enc_bad) begin
            enc_err_d = 1'b1;
          end else begin
            push = 1'b1;
            // A zero low part means the LUI alone is exact.
            if (req_op == OP_LI && !li_small && req_imm[11:0] != 12'd0) begin
              state_d = ST_EXPAND;
              li_rd_d = req_rd;
              li_lo_d = req_imm[11:0];
            end
          end
        end
      end
      ST_EXPAND: begin
        if (!fifo_full) begin
          push      = 1'b1;
          push_data = {li_lo_q, li_rd_q, 3'b000, li_rd_q, OPC_OPIMM};
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      li_rd_q   <= '0;
      li_lo_q   <= '0;
      enc_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      li_rd_q   <= li_rd_d;
      li_lo_q   <= li_lo_d;
      enc_err_q <= enc_err_d;
    end
  end

  inst_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (INST_LENGTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .wr_data  (push_data),
    .pop      (inst_valid && inst_ready),
    .rd_valid (inst_valid),
    .rd_data  (inst_data),
    .full     (fifo_full)
  );

endmodule : inst_encoder

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder
// Purpose: directed self-checking bench for inst_encoder (default FIFO_DEPTH 4).
module tb_inst_encoder;
  import renas_package::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  enc_op_e     req_op;
  logic [2:0]  req_funct3;
  logic        req_alt;
  logic [4:0]  req_rd, req_rs1, req_rs2;
  logic [31:0] req_imm;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic        enc_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  inst_encoder #(.FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_funct3 (req_funct3),
    .req_alt    (req_alt),
    .req_rd     (req_rd),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_imm    (req_imm),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_data  (inst_data),
    .enc_err    (enc_err)
  );

  // Present one request for one cycle; returns #1 after the sampling edge.
  task automatic drive(input enc_op_e op, input logic [2:0] f3, input logic alt,
                       input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm);
    @(negedge clk);
    req_op = op; req_funct3 = f3; req_alt = alt;
    req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Pop the head over one edge; called and returns #1 after an edge.
  task automatic pop_one();
    inst_ready = 1'b1;
    @(posedge clk);
    #1 inst_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (inst_valid !== 1'b0 || enc_err !== 1'b0 || inst_data !== 32'h0 || req_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: valid=%b err=%b data=%h ready=%b, want 0 0 0 0",
               inst_valid, enc_err, inst_data, req_ready);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: got %b want 1", req_ready);
    end
    $display("[TB] reset checked");
  endtask

  // Single-word requests: check head one cycle after acceptance, then pop.
  task automatic test_single_words();
    enc_op_e     ops  [7] = '{OP_OPIMM, OP_BRANCH, OP_JAL, OP_STORE, OP_OP, OP_NOP, OP_AUIPC};
    logic [2:0]  f3s  [7] = '{3'd0, 3'd0, 3'd0, 3'd2, 3'd0, 3'd0, 3'd0};
    logic        alts [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [4:0]  rds  [7] = '{5'd1, 5'd0, 5'd1, 5'd0, 5'd3, 5'd0, 5'd1};
    logic [4:0]  rs1s [7] = '{5'd0, 5'd1, 5'd0, 5'd1, 5'd1, 5'd0, 5'd0};
    logic [4:0]  rs2s [7] = '{5'd0, 5'd2, 5'd0, 5'd2, 5'd2, 5'd0, 5'd0};
    logic [31:0] imms [7] = '{32'd5, 32'd8, 32'd8, 32'd4, 32'd0, 32'd0, 32'h1000};
    logic [31:0] exps [7] = '{32'h00500093, 32'h00208463, 32'h008000EF, 32'h0020A223,
                              32'h402081B3, 32'h00000013, 32'h00001097};
    for (int i = 0; i < 7; i++) begin
      drive(ops[i], f3s[i], alts[i], rds[i], rs1s[i], rs2s[i], imms[i]);
      tests++;
      if (inst_valid !== 1'b1 || inst_data !== exps[i]) begin
        fails++;
        $display("FAIL single_word[%0d]: valid=%b data=%h want valid=1 data=%h",
                 i, inst_valid, inst_data, exps[i]);
      end
      $display("[TB] single op=%0d data=%h", ops[i], inst_data);
      pop_one();
    end
  endtask

  task automatic test_li_expand();
    logic [4:0]  rds  [2] = '{5'd2, 5'd3};
    logic [31:0] imms [2] = '{32'h12345678, 32'h00000800};
    logic [31:0] lui  [2] = '{32'h12345137, 32'h000011B7};
    logic [31:0] addi [2] = '{32'h67810113, 32'h80018193};
    for (int i = 0; i < 2; i++) begin
      drive(OP_LI, 3'd0, 1'b0, rds[i], 5'd0, 5'd0, imms[i]);
      tests++;
      if (inst_data !== lui[i] || req_ready !== 1'b0) begin
        fails++;
        $display("FAIL li_lui[%0d]: data=%h ready=%b want data=%h ready=0",
                 i, inst_data, req_ready, lui[i]);
      end
      @(posedge clk); #1;
      tests++;
      if (req_ready !== 1'b1) begin
        fails++;
        $display("FAIL li_ready_after_expand[%0d]: got %b want 1", i, req_ready);
      end
      pop_one();
      tests++;
      if (inst_valid !== 1'b1 || inst_data !== addi[i]) begin
        fails++;
        $display("FAIL li_addi[%0d]: valid=%b data=%h want valid=1 data=%h",
                 i, inst_valid, inst_data, addi[i]);
      end
      $display("[TB] li rd=%0d imm=%h -> %h %h", rds[i], imms[i], lui[i], inst_data);
      pop_one();
    end
  endtask

  task automatic test_li_short();
    // Small immediate: single ADDI from x0.
    drive(OP_LI, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF);
    tests++;
    if (inst_data !== 32'hFFF00293 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL li_small: data=%h ready=%b want data=fff00293 ready=1", inst_data, req_ready);
    end
    $display("[TB] li small -> %h", inst_data);
    pop_one();
    // Zero low part: LUI only, no ADDI follows.
    drive(OP_LI, 3'd0, 1'b0, 5'd6, 5'd0, 5'd0, 32'h00001000);
    tests++;
    if (inst_data !== 32'h00001337 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL li_lui_only: data=%h ready=%b want data=00001337 ready=1", inst_data, req_ready);
    end
    pop_one();
    tests++;
    if (inst_valid !== 1'b0) begin
      fails++;
      $display("FAIL li_no_addi: valid=%b data=%h want valid=0", inst_valid, inst_data);
    end
    $display("[TB] li lui-only checked");
  endtask

  task automatic test_full();
    for (int k = 1; k <= 4; k++) drive(OP_OPIMM, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'(k));
    tests++;
    if (req_ready !== 1'b0) begin
      fails++;
      $display("FAIL full_ready: got %b want 0", req_ready);
    end
    @(posedge clk); #1;
    tests++;
    if (inst_data !== 32'h00100093) begin
      fails++;
      $display("FAIL full_hold: data=%h want 00100093", inst_data);
    end
    for (int k = 1; k <= 4; k++) begin
      tests++;
      if (inst_valid !== 1'b1 || inst_data !== ((32'(k) << 20) | 32'h93)) begin
        fails++;
        $display("FAIL full_drain[%0d]: valid=%b data=%h want %h",
                 k, inst_valid, inst_data, (32'(k) << 20) | 32'h93);
      end
      $display("[TB] drain %0d data=%h", k, inst_data);
      pop_one();
    end
    tests++;
    if (inst_valid !== 1'b0) begin
      fails++;
      $display("FAIL full_empty: valid=%b want 0", inst_valid);
    end
  endtask

  task automatic test_back_to_back();
    inst_ready = 1'b1;
    for (int k = 7; k <= 9; k++) begin
      drive(OP_OPIMM, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'(k));
      tests++;
      if (inst_valid !== 1'b1 || inst_data !== ((32'(k) << 20) | 32'h113)) begin
        fails++;
        $display("FAIL b2b[%0d]: valid=%b data=%h want %h",
                 k, inst_valid, inst_data, (32'(k) << 20) | 32'h113);
      end
      $display("[TB] b2b %0d data=%h", k, inst_data);
    end
    @(posedge clk); #1;
    inst_ready = 1'b0;
    tests++;
    if (inst_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_empty: valid=%b want 0", inst_valid);
    end
  endtask

  task automatic test_reset_mid_expand();
    drive(OP_LI, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'h12345678);
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (inst_valid !== 1'b0 || req_ready !== 1'b0 || inst_data !== 32'h0) begin
      fails++;
      $display("FAIL rst_expand: valid=%b ready=%b data=%h want 0 0 0",
               inst_valid, req_ready, inst_data);
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (inst_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_no_addi: valid=%b ready=%b want valid=0 ready=1", inst_valid, req_ready);
    end
    $display("[TB] reset mid-expand checked");
  endtask

  task automatic test_check();
    drive(OP_OPIMM, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048);
`ifdef RENAS_ENC_CHECK_EN
    tests++;
    if (enc_err !== 1'b1 || inst_valid !== 1'b0) begin
      fails++;
      $display("FAIL check_reject: err=%b valid=%b want err=1 valid=0", enc_err, inst_valid);
    end
    @(posedge clk); #1;
    tests++;
    if (enc_err !== 1'b0) begin
      fails++;
      $display("FAIL check_pulse_width: err=%b want 0", enc_err);
    end
`else
    tests++;
    if (enc_err !== 1'b0 || inst_valid !== 1'b1 || inst_data !== 32'h80000093) begin
      fails++;
      $display("FAIL truncate: err=%b valid=%b data=%h want err=0 valid=1 data=80000093",
               enc_err, inst_valid, inst_data);
    end
    pop_one();
`endif
    $display("[TB] imm=2048 err=%b valid=%b", enc_err, inst_valid);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; inst_ready = 1'b0;
    req_op = OP_NOP; req_funct3 = '0; req_alt = 1'b0;
    req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
    test_reset();
    test_single_words();
    test_li_expand();
    test_li_short();
    test_full();
    test_back_to_back();
    test_reset_mid_expand();
    test_check();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule : tb_inst_encoder
